vga_grid_generator: RTL and testbench
=====================================

# vga_grid_generator

- Parametrised VGA timing and pixel generator for the Game-of-Life display.
- Produces programmable hsync, vsync and data-enable, and draws a GRID_W × GRID_H cell grid anchored at the top-left of the active area.
- Each cell is CELL_W × CELL_H pixels with a BORDER-pixel frame. Cell interiors take their colour from an external 1-bit cell-state memory, read through a fixed-latency port.
- Sits between the cell-state RAM written by the life engine and the video DAC/HDMI transmitter.

## Interface
- GRID_W, 6: grid columns.
- GRID_H, 6: grid rows.
- CELL_W, 64: cell width in pixels.
- CELL_H, 64: cell height in pixels.
- BORDER, 3: frame thickness in pixels; must satisfy 2*BORDER < CELL_W and 2*BORDER < CELL_H.
- COLOR_DEAD, 24'h000000: RGB of a state-0 interior.
- COLOR_ALIVE, 24'h00FF00: RGB of a state-1 interior.
- COLOR_BORDER, 24'hFFFFFF: RGB of frame pixels.
- COLOR_OUT, 24'h999900: RGB of active pixels outside the grid.
- COLOR_CURSOR, 24'hFF0000: RGB of the cursor cell frame (macro only).
- ADDR_W, $clog2(GRID_W*GRID_H): derived; cell address width.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- h_total, h_sync, h_start, h_end  in  12 each  horizontal timing.
- v_total, v_sync, v_start, v_end  in  12 each  vertical timing.
- cell_rd  out  1  cell read strobe.
- cell_addr  out  ADDR_W  row*GRID_W+col.
- cell_state  in  1  read data, valid exactly 1 clk after cell_rd.
- vblank_start  out  1  one-clk pulse at the start of vertical blanking.
- cursor_col  in  $clog2(GRID_W)  cursor column (macro only).
- cursor_row  in  $clog2(GRID_H)  cursor row (macro only).
- vga_hs, vga_vs, vga_de  out  1 each  sync outputs, low-active sync.
- vga_r, vga_g, vga_b  out  8 each  pixel colour.

## Operation
- **Horizontal counter:** h_count runs 0..h_total, then wraps to 0. The wrap uses `>=`, so lowering h_total mid-line wraps immediately.
- **Vertical counter:** v_count advances on each h_count wrap, runs 0..v_total, and wraps the same way.
- **Sync:** hs is low while h_count < h_sync. vs is low while v_count < v_sync.
- **Active area:** horizontal active when h_start ≤ h_count < h_end, giving x = h_count−h_start. Vertical active when v_start ≤ v_count < v_end, giving y = v_count−v_start. de = h_active & v_active.
- **Cell position without dividers:**
  - col/xoff counters reset at x=0. xoff increments each pixel; at CELL_W−1 it returns to 0 and col increments.
  - row/yoff counters reset at y=0 and advance at the end of each active line using the same rule.
- **Pixel classification:**
  - col ≥ GRID_W or row ≥ GRID_H → COLOR_OUT.
  - xoff < BORDER or xoff ≥ CELL_W−BORDER, or yoff < BORDER or yoff ≥ CELL_H−BORDER → COLOR_BORDER.
  - Otherwise cell_state selects COLOR_ALIVE or COLOR_DEAD.
  - Outside de → RGB = 0.
- **Cell reads:** cell_rd is asserted only for interior pixels inside the grid. cell_addr holds its last value otherwise.
- **Clipping:** a grid larger than the active area is clipped silently; no error is raised.
- **vblank_start:** registered. Pulses for one clk in the cycle after the counters reach v_count == v_end, h_count == 0.

## Timing
- **Pipeline:** stage 0 counters → stage 1 classification + cell_addr/cell_rd registered → stage 2 cell_state sampled → stage 3 output registers.
- **Alignment:** hs, vs and de are delayed through matching registers, so all outputs emerge 3 clk after their counter state and stay mutually aligned.
- **Reset values:**
  - Outputs: vga_hs=1, vga_vs=1, vga_de=0, RGB=0, cell_rd=0, cell_addr=0, vblank_start=0.
  - Internal: counters 0, pipeline cleared.
- **Reset mid-frame:** asynchronous reset forces all reset values immediately. Counting restarts from h_count = v_count = 0 on the first clk after release.
- **Border vs. cell boundary:** when a border pixel also lies on a cell boundary, the border takes priority; there is no cell read.
- **Line boundaries:** a line ending mid-cell restarts col/xoff at 0 on the next line.

## Configuration
- **VGA_GRID_CURSOR_EN defined:**
  - cursor_col and cursor_row ports exist.
  - Frame pixels of the cell with col == cursor_col and row == cursor_row render COLOR_CURSOR.
  - Cursor inputs are sampled at stage 1.
- **Not defined:** the ports are absent and all frames render COLOR_BORDER.

## Test plan
Common configuration: h_total=15, h_sync=2, h_start=4, h_end=12, v_total=9, v_sync=1, v_start=2, v_end=8, GRID_W=2, GRID_H=2, CELL_W=3, CELL_H=3, BORDER=1.

- **Reset:** hold reset_n low → hs=vs=1, de=0, RGB=0. Release → hs low for 2 clk every 16, vs low for 16 clk every 160, de high for 8 clk on 6 lines, all offset 3 clk from the counters.
- **Grid colours:** cells 0 and 3 alive, cells 1 and 2 dead.
  - Line y=1: x=0,2,3,5 → FFFFFF; x=1 → 00FF00; x=4 → 000000; x=6,7 → 999900.
  - Line y=4: x=1 → 000000; x=4 → 00FF00.
  - Line y=1 reads: cell_rd fires only at x=1 and x=4, with addresses 0 and 1.
- **Out-of-grid lines:** line y=5 (row 1, yoff=2) → all grid pixels FFFFFF. vblank_start pulses once per frame, 1 clk wide.
- **Reset mid-frame:** assert reset_n low at h_count=7, v_count=4 → outputs take reset values the same clk; the first frame after release matches the reset-scenario timing.
- **Timing change:** change h_total from 15 to 11 while h_count=13 → wrap on the next clk; the line period becomes 12.
- **Cursor (VGA_GRID_CURSOR_EN):** cursor_col=1, cursor_row=0 → cell 1 frame pixels FF0000, cell 0 frame FFFFFF. Without the macro, both frames are FFFFFF.

Source files
------------

// File: rtl/vga_grid_generator_if.sv
// vga_grid_generator_if: read port between the grid renderer and the cell-state RAM.
// The master issues a read strobe plus address; the RAM returns the state one clock later.
interface vga_grid_generator_if #(
    parameter int ADDR_W = 6
);
    logic              cell_rd;
    logic [ADDR_W-1:0] cell_addr;
    logic              cell_state;

    modport master (
        output cell_rd,
        output cell_addr,
        input  cell_state
    );

    modport slave (
        input  cell_rd,
        input  cell_addr,
        output cell_state
    );
endinterface

// File: rtl/vga_grid_generator.sv
// vga_grid_generator: programmable VGA timing plus a Game-of-Life cell grid renderer.
// Define VGA_GRID_CURSOR_EN to add cursor_col/cursor_row and a highlighted cursor cell frame.
module vga_grid_generator #(
    parameter int          GRID_W       = 6,
    parameter int          GRID_H       = 6,
    parameter int          CELL_W       = 64,
    parameter int          CELL_H       = 64,
    parameter int          BORDER       = 3,
    parameter logic [23:0] COLOR_DEAD   = 24'h000000,
    parameter logic [23:0] COLOR_ALIVE  = 24'h00FF00,
    parameter logic [23:0] COLOR_BORDER = 24'hFFFFFF,
    parameter logic [23:0] COLOR_OUT    = 24'h999900,
`ifdef VGA_GRID_CURSOR_EN
    parameter logic [23:0] COLOR_CURSOR = 24'hFF0000,
`endif
    parameter int          ADDR_W       = $clog2(GRID_W * GRID_H)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] h_total,
    input  logic [11:0] h_sync,
    input  logic [11:0] h_start,
    input  logic [11:0] h_end,
    input  logic [11:0] v_total,
    input  logic [11:0] v_sync,
    input  logic [11:0] v_start,
    input  logic [11:0] v_end,
    vga_grid_generator_if.master cell_bus,
    output logic        vblank_start,
`ifdef VGA_GRID_CURSOR_EN
    input  logic [((GRID_W > 1) ? $clog2(GRID_W) : 1)-1:0] cursor_col,
    input  logic [((GRID_H > 1) ? $clog2(GRID_H) : 1)-1:0] cursor_row,
`endif
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    // Column/row counters saturate at GRID_W/GRID_H so a clipped-off grid never wraps back in.
    localparam int CW = $clog2(GRID_W + 1);
    localparam int RW = $clog2(GRID_H + 1);
    localparam int XW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int YW = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    localparam logic [CW-1:0]     COL_LIMIT  = CW'(GRID_W);
    localparam logic [RW-1:0]     ROW_LIMIT  = RW'(GRID_H);
    localparam logic [XW-1:0]     X_LAST     = XW'(CELL_W - 1);
    localparam logic [YW-1:0]     Y_LAST     = YW'(CELL_H - 1);
    localparam logic [XW-1:0]     X_IN_BEG   = XW'(BORDER);
    localparam logic [XW-1:0]     X_IN_END   = XW'(CELL_W - BORDER);
    localparam logic [YW-1:0]     Y_IN_BEG   = YW'(BORDER);
    localparam logic [YW-1:0]     Y_IN_END   = YW'(CELL_H - BORDER);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(GRID_W);

    typedef enum logic [2:0] {
        PIX_BLANK,
        PIX_OUT,
        PIX_BORDER,
        PIX_CURSOR,
        PIX_CELL
    } pix_class_t;

    // ---------------- stage 0: raster counters ----------------
    logic [11:0]   h_count, v_count, h_next, v_next;
    logic          h_wrap, h_active, v_active;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [XW-1:0] xoff;
    logic [YW-1:0] yoff;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        h_wrap = (h_count >= h_total);
        h_next = h_wrap ? 12'd0 : h_count + 12'd1;
        v_next = v_count;
        if (h_wrap) begin
            v_next = (v_count >= v_total) ? 12'd0 : v_count + 12'd1;
        end
        h_active = (h_count >= h_start) && (h_count < h_end);
        v_active = (v_count >= v_start) && (v_count < v_end);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_count <= 12'd0;
            v_count <= 12'd0;
        end else begin
            h_count <= h_next;
            v_count <= v_next;
        end
    end

    // Cell position tracked by offset counters; they restart whenever the next pixel is x = 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col  <= '0;
            xoff <= '0;
        end else if (h_next == h_start) begin
            col  <= '0;
            xoff <= '0;
        end else if (h_active) begin
            if (xoff == X_LAST) begin
                xoff <= '0;
                if (col != COL_LIMIT) col <= col + 1'b1;
            end else begin
                xoff <= xoff + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row  <= '0;
            yoff <= '0;
        end else if (h_wrap) begin
            if (v_next == v_start) begin
                row  <= '0;
                yoff <= '0;
            end else if (v_active) begin
                if (yoff == Y_LAST) begin
                    yoff <= '0;
                    if (row != ROW_LIMIT) row <= row + 1'b1;
                end else begin
                    yoff <= yoff + 1'b1;
                end
            end
        end
    end

    // ---------------- stage 0 -> 1: classification ----------------
    pix_class_t        class_next;
    logic              de_next, in_grid, on_border, on_cursor, rd_next;
    logic [ADDR_W-1:0] addr_next;

    always_comb begin
        de_next   = h_active && v_active;
        in_grid   = (col < COL_LIMIT) && (row < ROW_LIMIT);
        on_border = (xoff < X_IN_BEG) || (xoff >= X_IN_END) ||
                    (yoff < Y_IN_BEG) || (yoff >= Y_IN_END);
`ifdef VGA_GRID_CURSOR_EN
        on_cursor = (col == CW'(cursor_col)) && (row == RW'(cursor_row));
`else
        on_cursor = 1'b0;
`endif
        addr_next  = ADDR_W'(row) * ROW_STRIDE + ADDR_W'(col);
        class_next = PIX_BLANK;
        rd_next    = 1'b0;
        if (de_next) begin
            if (!in_grid) begin
                class_next = PIX_OUT;
            end else if (on_border) begin
                class_next = on_cursor ? PIX_CURSOR : PIX_BORDER;
            end else begin
                class_next = PIX_CELL;
                rd_next    = 1'b1;
            end
        end
    end

    // ---------------- stages 1 and 2: aligned delay line ----------------
    pix_class_t class_s1, class_s2;
    logic       hs_s1, vs_s1, de_s1, hs_s2, vs_s2, de_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            class_s1           <= PIX_BLANK;
            hs_s1              <= 1'b1;
            vs_s1              <= 1'b1;
            de_s1              <= 1'b0;
            class_s2           <= PIX_BLANK;
            hs_s2              <= 1'b1;
            vs_s2              <= 1'b1;
            de_s2              <= 1'b0;
            cell_bus.cell_rd   <= 1'b0;
            cell_bus.cell_addr <= '0;
            vblank_start       <= 1'b0;
        end else begin
            class_s1         <= class_next;
            hs_s1            <= (h_count >= h_sync);
            vs_s1            <= (v_count >= v_sync);
            de_s1            <= de_next;
            class_s2         <= class_s1;
            hs_s2            <= hs_s1;
            vs_s2            <= vs_s1;
            de_s2            <= de_s1;
            cell_bus.cell_rd <= rd_next;
            // Address holds its last value between reads.
            if (rd_next) cell_bus.cell_addr <= addr_next;
            vblank_start     <= (v_count == v_end) && (h_count == 12'd0);
        end
    end

    // ---------------- stage 3: colour select and output registers ----------------
    logic [23:0] rgb_next;

    always_comb begin
        rgb_next = 24'h000000;
        case (class_s2)
            PIX_OUT:    rgb_next = COLOR_OUT;
            PIX_BORDER: rgb_next = COLOR_BORDER;
`ifdef VGA_GRID_CURSOR_EN
            PIX_CURSOR: rgb_next = COLOR_CURSOR;
`else
            PIX_CURSOR: rgb_next = COLOR_BORDER;
`endif
            PIX_CELL:   rgb_next = cell_bus.cell_state ? COLOR_ALIVE : COLOR_DEAD;
            default:    rgb_next = 24'h000000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
            vga_de <= 1'b0;
            vga_r  <= 8'd0;
            vga_g  <= 8'd0;
            vga_b  <= 8'd0;
        end else begin
            vga_hs <= hs_s2;
            vga_vs <= vs_s2;
            vga_de <= de_s2;
            vga_r  <= rgb_next[23:16];
            vga_g  <= rgb_next[15:8];
            vga_b  <= rgb_next[7:0];
        end
    end

endmodule

// File: tb/tb_vga_grid_generator.sv
// tb_vga_grid_generator: directed bench for a 2x2 grid of 3x3 cells on a 16x10 raster.
// Build with VGA_GRID_CURSOR_EN defined to exercise the cursor frame colour.
module tb_vga_grid_generator;

    logic        clk;
    logic        reset_n;
    logic [11:0] h_total, h_sync, h_start, h_end;
    logic [11:0] v_total, v_sync, v_start, v_end;
    logic        vblank_start;
    logic        vga_hs, vga_vs, vga_de;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic [23:0] rgb;
    logic        mem [4];
`ifdef VGA_GRID_CURSOR_EN
    logic        cursor_col, cursor_row;
    localparam logic [23:0] C_FRAME1 = 24'hFF0000;
`else
    localparam logic [23:0] C_FRAME1 = 24'hFFFFFF;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    assign rgb = {vga_r, vga_g, vga_b};

    vga_grid_generator_if #(.ADDR_W(2)) cell_bus ();

    vga_grid_generator #(
        .GRID_W(2), .GRID_H(2), .CELL_W(3), .CELL_H(3), .BORDER(1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .h_total      (h_total),
        .h_sync       (h_sync),
        .h_start      (h_start),
        .h_end        (h_end),
        .v_total      (v_total),
        .v_sync       (v_sync),
        .v_start      (v_start),
        .v_end        (v_end),
        .cell_bus     (cell_bus),
        .vblank_start (vblank_start),
`ifdef VGA_GRID_CURSOR_EN
        .cursor_col   (cursor_col),
        .cursor_row   (cursor_row),
`endif
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs),
        .vga_de       (vga_de),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b)
    );

    // Cell-state RAM with one clock of read latency.
    always @(posedge clk) begin
        if (cell_bus.cell_rd === 1'b1) cell_bus.cell_state <= mem[cell_bus.cell_addr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Each tick advances one posedge and lands 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
    endtask

    task automatic goto(input int p);
        while (cyc < p) tick();
        checks++;
        if (cyc != p) begin
            failures++;
            $display("FAIL schedule got cycle %0d expected %0d", cyc, p);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    // Sample cycle of the output for pixel (x,y) of a frame starting at counter index base.
    function automatic int pix_at(input int x, input int y, input int base);
        return base + (y + 2) * 16 + (x + 4) + 3;
    endfunction

    task automatic check_reset_values(input string tag);
        checks++; if (vga_hs !== 1'b1) begin failures++; $display("FAIL %s_hs got %b expected 1", tag, vga_hs); end
        checks++; if (vga_vs !== 1'b1) begin failures++; $display("FAIL %s_vs got %b expected 1", tag, vga_vs); end
        checks++; if (vga_de !== 1'b0) begin failures++; $display("FAIL %s_de got %b expected 0", tag, vga_de); end
        checks++; if (rgb !== 24'h0) begin failures++; $display("FAIL %s_rgb got %h expected 000000", tag, rgb); end
        checks++; if (cell_bus.cell_rd !== 1'b0) begin failures++; $display("FAIL %s_cell_rd got %b expected 0", tag, cell_bus.cell_rd); end
        checks++; if (cell_bus.cell_addr !== 2'd0) begin failures++; $display("FAIL %s_cell_addr got %0d expected 0", tag, cell_bus.cell_addr); end
        checks++; if (vblank_start !== 1'b0) begin failures++; $display("FAIL %s_vblank got %b expected 0", tag, vblank_start); end
    endtask

    // Sync/de/vblank waveform for the first frame after a reset release.
    task automatic check_frame_timing(input string tag);
        int c, h, v;
        logic e_hs, e_vs, e_de, e_vb;
        for (int p = 0; p <= 162; p++) begin
            goto(p);
            if (p < 3) begin
                e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0;
            end else begin
                c = p - 3;
                h = c % 16;
                v = (c / 16) % 10;
                e_hs = (h >= 2);
                e_vs = (v >= 1);
                e_de = (h >= 4) && (h < 12) && (v >= 2) && (v < 8);
            end
            e_vb = (p >= 1) && (((p - 1) % 160) == 128);
            checks++; if (vga_hs !== e_hs) begin failures++; $display("FAIL %s_hs p=%0d got %b expected %b", tag, p, vga_hs, e_hs); end
            checks++; if (vga_vs !== e_vs) begin failures++; $display("FAIL %s_vs p=%0d got %b expected %b", tag, p, vga_vs, e_vs); end
            checks++; if (vga_de !== e_de) begin failures++; $display("FAIL %s_de p=%0d got %b expected %b", tag, p, vga_de, e_de); end
            checks++; if (vblank_start !== e_vb) begin failures++; $display("FAIL %s_vblank p=%0d got %b expected %b", tag, p, vblank_start, e_vb); end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_reset_values("reset_hold");
        release_reset();
        check_frame_timing("reset_frame");
    endtask

    // Frame 1, line y=1: reads only at interior pixels x=1 (cell 0) and x=4 (cell 1).
    task automatic test_cell_reads();
        logic       e_rd;
        logic [1:0] e_addr;
        for (int x = 0; x < 8; x++) begin
            goto(160 + 3 * 16 + (x + 4) + 1);
            e_rd = (x == 1) || (x == 4);
            checks++;
            if (cell_bus.cell_rd !== e_rd) begin
                failures++;
                $display("FAIL cell_rd x=%0d got %b expected %b", x, cell_bus.cell_rd, e_rd);
            end
            e_addr = (x == 0) ? 2'd3 : (x < 4) ? 2'd0 : 2'd1;
            checks++;
            if (cell_bus.cell_addr !== e_addr) begin
                failures++;
                $display("FAIL cell_addr x=%0d got %0d expected %0d", x, cell_bus.cell_addr, e_addr);
            end
        end
    endtask

    task automatic test_grid_colors();
        logic [23:0] exp_y1 [8];
        exp_y1 = '{24'hFFFFFF, 24'h00FF00, 24'hFFFFFF, C_FRAME1,
                   24'h000000, C_FRAME1, 24'h999900, 24'h999900};
        goto(320 + 3 * 16 + 3 + 3);
        checks++; if (vga_de !== 1'b0) begin failures++; $display("FAIL pre_active_de got %b expected 0", vga_de); end
        checks++; if (rgb !== 24'h0) begin failures++; $display("FAIL pre_active_rgb got %h expected 000000", rgb); end
        for (int x = 0; x < 8; x++) begin
            goto(pix_at(x, 1, 320));
            checks++;
            if (rgb !== exp_y1[x]) begin
                failures++;
                $display("FAIL y1_rgb x=%0d got %h expected %h", x, rgb, exp_y1[x]);
            end
            checks++; if (vga_de !== 1'b1) begin failures++; $display("FAIL y1_de x=%0d got %b expected 1", x, vga_de); end
        end
        goto(pix_at(1, 4, 320));
        checks++; if (rgb !== 24'h000000) begin failures++; $display("FAIL y4_cell2 got %h expected 000000", rgb); end
        goto(pix_at(4, 4, 320));
        checks++; if (rgb !== 24'h00FF00) begin failures++; $display("FAIL y4_cell3 got %h expected 00FF00", rgb); end
    endtask

    task automatic test_out_of_grid();
        logic [23:0] e_rgb;
        int          vb_high;
        for (int x = 0; x < 8; x++) begin
            goto(pix_at(x, 5, 480));
            e_rgb = (x < 6) ? 24'hFFFFFF : 24'h999900;
            checks++;
            if (rgb !== e_rgb) begin
                failures++;
                $display("FAIL y5_rgb x=%0d got %h expected %h", x, rgb, e_rgb);
            end
        end
        goto(pix_at(8, 5, 480));
        checks++; if (rgb !== 24'h0) begin failures++; $display("FAIL y5_blank_rgb got %h expected 000000", rgb); end
        vb_high = 0;
        for (int p = 608; p < 640; p++) begin
            goto(p);
            if (vblank_start === 1'b1) vb_high++;
        end
        checks++;
        if (vb_high != 1) begin
            failures++;
            $display("FAIL vblank_width got %0d high cycles expected 1", vb_high);
        end
    endtask

    task automatic test_cursor();
        logic [23:0] e_rgb;
        for (int x = 0; x < 6; x++) begin
            goto(pix_at(x, 0, 640));
            e_rgb = (x < 3) ? 24'hFFFFFF : C_FRAME1;
            checks++;
            if (rgb !== e_rgb) begin
                failures++;
                $display("FAIL cursor_y0 x=%0d got %h expected %h", x, rgb, e_rgb);
            end
        end
        goto(pix_at(3, 3, 640));
        checks++; if (rgb !== 24'hFFFFFF) begin failures++; $display("FAIL cursor_row1 got %h expected FFFFFF", rgb); end
    endtask

    task automatic test_reset_mid_frame();
        goto(800 + 4 * 16 + 7);
        checks++; if (vga_de !== 1'b1) begin failures++; $display("FAIL mid_pre_de got %b expected 1", vga_de); end
        reset_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        repeat (3) @(posedge clk);
        release_reset();
        check_frame_timing("mid_frame");
    endtask

    task automatic test_timing_change();
        int c;
        logic e_hs, e_de;
        c = 320 + 16 + 13;
        goto(c);
        h_total = 12'd11;
        for (int k = 0; k < 36; k++) begin
            goto(c + 1 + k + 3);
            e_hs = ((k % 12) >= 2);
            e_de = ((k % 12) >= 4);
            checks++; if (vga_hs !== e_hs) begin failures++; $display("FAIL tchg_hs k=%0d got %b expected %b", k, vga_hs, e_hs); end
            checks++; if (vga_de !== e_de) begin failures++; $display("FAIL tchg_de k=%0d got %b expected %b", k, vga_de, e_de); end
            checks++; if (vga_vs !== 1'b1) begin failures++; $display("FAIL tchg_vs k=%0d got %b expected 1", k, vga_vs); end
        end
        h_total = 12'd15;
    endtask

    initial begin
        h_total = 12'd15; h_sync = 12'd2; h_start = 12'd4; h_end = 12'd12;
        v_total = 12'd9;  v_sync = 12'd1; v_start = 12'd2; v_end = 12'd8;
        mem[0] = 1'b1; mem[1] = 1'b0; mem[2] = 1'b0; mem[3] = 1'b1;
`ifdef VGA_GRID_CURSOR_EN
        cursor_col = 1'b1;
        cursor_row = 1'b0;
`endif
        test_reset();
        test_cell_reads();
        test_grid_colors();
        test_out_of_grid();
        test_cursor();
        test_reset_mid_frame();
        test_timing_change();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
